// File: rtl/video_timing_gen.sv
// video_timing_gen: raster scan counters with registered sync/active/new-frame decode and frame counter.
// Define VTG_LATENCY_EN to delay the flag outputs by LATENCY cycles relative to the counts.
module video_timing_gen #(
  parameter int ACTIVE_H = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int ACTIVE_V = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int FC_WIDTH = 6,
  parameter int LATENCY  = 4,
  localparam int H_TOTAL = ACTIVE_H + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = ACTIVE_V + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic                clk_pixel_in,
  input  logic                rst_in,
  output logic [HW-1:0]       hcount_out,
  output logic [VW-1:0]       vcount_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                active_draw_out,
  output logic                new_frame_out,
  output logic [FC_WIDTH-1:0] frame_count_out
);
`ifdef VTG_LATENCY_EN
  localparam int LAT = LATENCY;
`else
  localparam int LAT = 0 * LATENCY;
`endif
  logic [HW-1:0]       h_q, h_d;
  logic [VW-1:0]       v_q, v_d;
  logic [FC_WIDTH-1:0] fc_q, fc_d;
  logic [3:0]          flg_q, flg_d, flg_o;
  logic                h_end, v_end;
  // Flags are decoded from the next counts so they register alongside them.
  always_comb begin
    h_end    = h_q == HW'(H_TOTAL - 1);
    v_end    = v_q == VW'(V_TOTAL - 1);
    h_d      = h_end ? '0 : h_q + 1'b1;
    v_d      = h_end ? (v_end ? '0 : v_q + 1'b1) : v_q;
    flg_d[0] = (h_d >= HW'(ACTIVE_H + H_FP)) && (h_d < HW'(ACTIVE_H + H_FP + H_SYNC));
    flg_d[1] = (v_d >= VW'(ACTIVE_V + V_FP)) && (v_d < VW'(ACTIVE_V + V_FP + V_SYNC));
    flg_d[2] = (h_d < HW'(ACTIVE_H)) && (v_d < VW'(ACTIVE_V));
    flg_d[3] = (h_d == HW'(ACTIVE_H)) && (v_d == VW'(ACTIVE_V));
    fc_d     = fc_q + FC_WIDTH'(flg_d[3]);
  end
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      h_q   <= HW'(H_TOTAL - 1);
      v_q   <= VW'(V_TOTAL - 1);
      fc_q  <= '0;
      flg_q <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      fc_q  <= fc_d;
      flg_q <= flg_d;
    end
  end
  generate
    if (LAT > 0) begin : g_dly
      logic [3:0] dly_q [LAT];
      always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
          for (int i = 0; i < LAT; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= flg_q;
          for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign flg_o = dly_q[LAT-1];
    end else begin : g_nodly
      assign flg_o = flg_q;
    end
  endgenerate
  assign hcount_out      = h_q;
  assign vcount_out      = v_q;
  assign frame_count_out = fc_q;
  assign hsync_out       = flg_o[0];
  assign vsync_out       = flg_o[1];
  assign active_draw_out = flg_o[2];
  assign new_frame_out   = flg_o[3];
endmodule
